lcd_refresh_controller: RTL and testbench

- Consumer stage directly downstream of the dual-read-port character RAM.
- Powers up and initialises an HD44780-compatible 2x16 character LCD in 4-bit mode.
- Then runs a continuous refresh loop: reads the 32-entry character buffer through one RAM read port and writes every character to the panel.
- Other logic updates the display by writing the RAM; this block never writes it.

---
 rtl/lcd_refresh_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_refresh_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_controller.sv
// HD44780 2x16 LCD driver: powers up the panel in 4-bit mode, then endlessly
// copies the 32-entry character RAM to the display, one nibble strobe at a time.
module lcd_refresh_controller #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int POWERUP_WAIT = 750000,
    parameter int E_PULSE      = 12,
    parameter int NIBBLE_GAP   = 50,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iReadData,
    output logic                  oLCD_E,
    output logic                  oLCD_RS,
    output logic                  oLCD_RW,
    output logic [3:0]            oLCD_Data,
    output logic                  oInitDone,
    output logic                  oFrameDone
);

    // Every wait lasts at least one cycle. The nibble gap includes the
    // one-cycle data setup before E, so its idle part is one shorter.
    localparam int PW_LEN  = (POWERUP_WAIT < 1) ? 1 : POWERUP_WAIT;
    localparam int PW3_LEN = (POWERUP_WAIT / 3 < 1) ? 1 : POWERUP_WAIT / 3;
    localparam int EP_LEN  = (E_PULSE < 1) ? 1 : E_PULSE;
    localparam int GAP_LEN = (NIBBLE_GAP - 1 < 1) ? 1 : NIBBLE_GAP - 1;
    localparam int CW_LEN  = (CMD_WAIT < 1) ? 1 : CMD_WAIT;
    localparam int CLR_LEN = (CLEAR_WAIT < 1) ? 1 : CLEAR_WAIT;
    localparam int MAX_A   = (PW_LEN > CLR_LEN) ? PW_LEN : CLR_LEN;
    localparam int MAX_B   = (CW_LEN > EP_LEN) ? CW_LEN : EP_LEN;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LEN = (MAX_C > GAP_LEN) ? MAX_C : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 2);

    localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
    localparam logic [2:0] ST_INIT_NIB  = 3'd1;
    localparam logic [2:0] ST_CFG       = 3'd2;
    localparam logic [2:0] ST_SET_ADDR  = 3'd3;
    localparam logic [2:0] ST_FETCH     = 3'd4;
    localparam logic [2:0] ST_SEND_CHAR = 3'd5;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_PULSE = 2'd1;
    localparam logic [1:0] PH_GAP   = 2'd2;
    localparam logic [1:0] PH_POST  = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             lower_q, lower_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_tgt;
    logic [1:0]       step_q, step_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       char_q, char_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [3:0]       data_q, data_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             cnt_done;
    logic             xfer_d;
    logic [7:0]       tx_byte;
    logic             unused_read_bits;

    assign unused_read_bits = ^iReadData[DATA_WIDTH-1:8];

    always_comb begin
        cnt_tgt = '0;
        case (state_q)
            ST_PWR_WAIT: cnt_tgt = CNT_W'(PW_LEN - 1);
            ST_FETCH:    cnt_tgt = CNT_W'(1);
            default: begin
                case (phase_q)
                    PH_PULSE: cnt_tgt = CNT_W'(EP_LEN - 1);
                    PH_GAP:   cnt_tgt = CNT_W'(GAP_LEN - 1);
                    PH_POST: begin
                        if (state_q == ST_INIT_NIB && step_q == 2'd0)
                            cnt_tgt = CNT_W'(PW3_LEN - 1);
                        else if (state_q == ST_CFG && step_q == 2'd3)
                            cnt_tgt = CNT_W'(CLR_LEN - 1);
                        else
                            cnt_tgt = CNT_W'(CW_LEN - 1);
                    end
                    default:  cnt_tgt = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        lower_d      = lower_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        idx_d        = idx_q;
        char_d       = char_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        rs_d         = rs_q;
        data_d       = data_q;
        tx_byte      = 8'h00;
        cnt_done     = (cnt_q == cnt_tgt);

        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = ST_INIT_NIB;
                    step_d  = 2'd0;
                    phase_d = PH_SETUP;
                    lower_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FETCH: begin
                // Address has been stable for a cycle; RAM data is valid now.
                if (cnt_done) begin
                    cnt_d   = '0;
                    char_d  = iReadData[7:0];
                    state_d = ST_SEND_CHAR;
                    phase_d = PH_SETUP;
                    lower_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT_NIB, ST_CFG, ST_SET_ADDR, ST_SEND_CHAR: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    case (phase_q)
                        PH_SETUP: phase_d = PH_PULSE;
                        PH_PULSE: phase_d = (!lower_q && state_q != ST_INIT_NIB) ? PH_GAP : PH_POST;
                        PH_GAP: begin
                            lower_d = 1'b1;
                            phase_d = PH_SETUP;
                        end
                        default: begin
                            lower_d = 1'b0;
                            phase_d = PH_SETUP;
                            case (state_q)
                                ST_INIT_NIB: begin
                                    step_d = step_q + 2'd1;
                                    if (step_q == 2'd3)
                                        state_d = ST_CFG;
                                end
                                ST_CFG: begin
                                    step_d = step_q + 2'd1;
                                    if (step_q == 2'd3) begin
                                        init_done_d = 1'b1;
                                        idx_d       = 5'd0;
                                        state_d     = ST_SET_ADDR;
                                    end
                                end
                                ST_SET_ADDR: state_d = ST_FETCH;
                                default: begin
                                    idx_d = idx_q + 5'd1;
                                    if (idx_q == 5'd31) begin
                                        frame_done_d = 1'b1;
                                        state_d      = ST_SET_ADDR;
                                    end else if (idx_q == 5'd15) begin
                                        state_d = ST_SET_ADDR;
                                    end else begin
                                        state_d = ST_FETCH;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        // Output nibble/RS are loaded on entry to setup and then left alone,
        // which gives the hold-after-E-fall for free.
        case (state_d)
            ST_INIT_NIB: tx_byte = (step_d == 2'd3) ? 8'h20 : 8'h30;
            ST_CFG: begin
                case (step_d)
                    2'd0:    tx_byte = 8'h28;
                    2'd1:    tx_byte = 8'h06;
                    2'd2:    tx_byte = 8'h0C;
                    default: tx_byte = 8'h01;
                endcase
            end
            ST_SET_ADDR:  tx_byte = idx_d[4] ? 8'hC0 : 8'h80;
            ST_SEND_CHAR: tx_byte = char_d;
            default:      tx_byte = 8'h00;
        endcase

        xfer_d = (state_d == ST_INIT_NIB) || (state_d == ST_CFG) ||
                 (state_d == ST_SET_ADDR) || (state_d == ST_SEND_CHAR);
        if (xfer_d && phase_d == PH_SETUP) begin
            data_d = lower_d ? tx_byte[3:0] : tx_byte[7:4];
            rs_d   = (state_d == ST_SEND_CHAR);
        end
        e_d = xfer_d && (phase_d == PH_PULSE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_PWR_WAIT;
            phase_q      <= PH_SETUP;
            lower_q      <= 1'b0;
            cnt_q        <= '0;
            step_q       <= 2'd0;
            idx_q        <= 5'd0;
            char_q       <= 8'h00;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 4'h0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            lower_q      <= lower_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            char_q       <= char_d;
            e_q          <= e_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign oReadAddress = ADDR_WIDTH'(idx_q);
    assign oLCD_E       = e_q;
    assign oLCD_RS      = rs_q;
    assign oLCD_RW      = 1'b0;
    assign oLCD_Data    = data_q;
    assign oInitDone    = init_done_q;
    assign oFrameDone   = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// Directed bench for lcd_refresh_controller: watches every E strobe and compares
// the nibble stream and strobe timing against hand-built expectations.
module tb_lcd_refresh_controller;

    localparam int PW  = 30;
    localparam int EP  = 2;
    localparam int NG  = 3;
    localparam int CW  = 5;
    localparam int CLW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr;
    logic [15:0] rd_q;
    logic        e, rs, rw, init_done, frame_done;
    logic [3:0]  d;
    logic [15:0] ram [0:255];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_q <= ram[addr];

    lcd_refresh_controller #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .POWERUP_WAIT(PW), .E_PULSE(EP),
        .NIBBLE_GAP(NG), .CMD_WAIT(CW), .CLEAR_WAIT(CLW)
    ) dut (
        .Clock(clk), .Reset(rst), .oReadAddress(addr), .iReadData(rd_q),
        .oLCD_E(e), .oLCD_RS(rs), .oLCD_RW(rw), .oLCD_Data(d),
        .oInitDone(init_done), .oFrameDone(frame_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor
    bit         mon_en = 1'b0;
    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_fd = 1'b0, prev_init = 1'b0;
    logic [3:0] prev_d = 4'h0;
    logic [4:0] cur;
    logic [4:0] ev_q [$];
    int         rise_q [$];
    int         fall_q [$];
    int         hi_cnt = 0, fd_cnt = 0, fd_long = 0, fd_t = 0, init_t = 0;
    bit         stable = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (e && !prev_e) begin
                    check_value("setup", {prev_rs, prev_d}, {rs, d});
                    check_value("rw", rw, 0);
                    ev_q.push_back({rs, d});
                    rise_q.push_back(cyc);
                    cur    = {rs, d};
                    hi_cnt = 1;
                    stable = 1'b1;
                end else if (e && prev_e) begin
                    hi_cnt++;
                    if ({rs, d} !== cur) stable = 1'b0;
                end else if (!e && prev_e) begin
                    check_value("e_width", hi_cnt, EP);
                    check_value("hold", {stable, rs, d}, {1'b1, cur});
                    fall_q.push_back(cyc);
                end
                if (frame_done) begin
                    fd_cnt++;
                    fd_t = cyc;
                    if (prev_fd) fd_long++;
                end
                if (init_done && !prev_init) init_t = cyc;
            end
            prev_e    = e;
            prev_rs   = rs;
            prev_d    = d;
            prev_fd   = frame_done;
            prev_init = init_done;
        end
    end

    logic [4:0] exp_q [$];

    task automatic push_byte(input logic rs_v, input logic [7:0] b);
        exp_q.push_back({rs_v, b[7:4]});
        exp_q.push_back({rs_v, b[3:0]});
    endtask

    function automatic logic [7:0] exp_char(input int frame, input int i);
        if (i == 31) return 8'hFF;
        if (frame == 2 && i == 0) return 8'h00;
        if (frame == 2 && i == 5) return 8'h7A;
        return 8'(8'h41 + i);
    endfunction

    task automatic check_outputs_reset(input string tag);
        check_value({tag, "_e"}, e, 0);
        check_value({tag, "_rs"}, rs, 0);
        check_value({tag, "_rw"}, rw, 0);
        check_value({tag, "_data"}, d, 0);
        check_value({tag, "_addr"}, addr, 0);
        check_value({tag, "_init"}, init_done, 0);
        check_value({tag, "_frame"}, frame_done, 0);
    endtask

    int rst_cyc = 0;

    initial begin
        int n;
        for (int i = 0; i < 256; i++)
            ram[i] = (i < 32) ? {8'hAB, 8'(8'h41 + i)} : 16'hAB00;

        exp_q.push_back(5'h03); exp_q.push_back(5'h03);
        exp_q.push_back(5'h03); exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
        for (int f = 1; f <= 2; f++) begin
            push_byte(1'b0, 8'h80);
            for (int i = 0; i < 16; i++) push_byte(1'b1, exp_char(f, i));
            push_byte(1'b0, 8'hC0);
            for (int i = 16; i < 32; i++) push_byte(1'b1, exp_char(f, i));
        end
        push_byte(1'b0, 8'h80);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst     = 1'b0;
        rst_cyc = cyc;
        mon_en  = 1'b1;

        // Rewrite RAM once index 5 of frame 1 has been latched.
        n = 0;
        while (!(addr == 8'd6 && init_done === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_value("wait_idx6", (n < 5000), 1);
        ram[5]  = 16'h007A;
        ram[0]  = 16'h0000;
        ram[31] = 16'h00FF;

        n = 0;
        while (ev_q.size() < exp_q.size() && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_value("wait_frames", (n < 20000), 1);

        for (int k = 0; k < exp_q.size(); k++) begin
            logic [4:0] got;
            got = (k < ev_q.size()) ? ev_q[k] : 5'h1F;
            $display("nibble %0d rs=%0b d=0x%0h", k, got[4], got[3:0]);
            check_value($sformatf("nib%0d", k), got, exp_q[k]);
        end

        if (fall_q.size() >= 148 && rise_q.size() >= 149) begin
            check_value("pwr_wait", rise_q[0] - rst_cyc, PW + 1);
            check_value("init_wait", rise_q[1] - fall_q[0], PW / 3 + 1);
            check_value("nibble_gap", rise_q[5] - fall_q[4], NG);
            check_value("clear_wait", init_t - fall_q[11], CLW);
            check_value("char_gap", rise_q[16] - fall_q[15], CW + 3);
            check_value("wrap_gap", rise_q[148] - fall_q[147], CW + 1);
            check_value("frame_pulse_t", fd_t - fall_q[147], CW);
        end else begin
            check_value("event_count", rise_q.size(), 149);
        end
        check_value("frame_pulses", fd_cnt, 2);
        check_value("frame_pulse_len", fd_long, 0);

        // Reset while E is high mid-frame.
        n = 0;
        while (e !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value("wait_e_high", e, 1);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_outputs_reset("midreset");
        rst     = 1'b0;
        rst_cyc = cyc;
        ev_q.delete();
        rise_q.delete();
        fall_q.delete();
        init_t  = 0;
        mon_en  = 1'b1;

        n = 0;
        while (ev_q.size() < 14 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_value("wait_reinit", (n < 5000), 1);
        for (int k = 0; k < 14; k++) begin
            logic [4:0] got;
            got = (k < ev_q.size()) ? ev_q[k] : 5'h1F;
            $display("reinit nibble %0d rs=%0b d=0x%0h", k, got[4], got[3:0]);
            check_value($sformatf("reinit_nib%0d", k), got, exp_q[k]);
        end
        if (fall_q.size() >= 12 && rise_q.size() >= 1) begin
            check_value("reinit_pwr_wait", rise_q[0] - rst_cyc, PW + 1);
            check_value("reinit_clear_wait", init_t - fall_q[11], CLW);
        end else begin
            check_value("reinit_events", fall_q.size(), 12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
